// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the sequential signed multiplier with BCD display:
//   state_e     - controller FSM state encoding
//   Add3Thresh  - double-dabble correction threshold (digit >= 5 gets +3)
//   clog2       - ceiling log2, usable in constant expressions
//   off_width   - width of the display-window offset (never below 1)
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMult = 2'd1,
    StConv = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic [3:0] Add3Thresh = 4'd5;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < {32'd0, value}) res = i + 1;
    end
    return res;
  endfunction

  function automatic int unsigned off_width(input int unsigned digits, input int unsigned window);
    int unsigned w;
    w = clog2(digits - window + 1);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-add-3), one input bit per cycle.
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_load        - capture i_bin and start a conversion (IN_W steps follow)
//   i_bin         - unsigned binary value to convert
//   o_busy        - conversion in progress
//   o_done        - high during the final step; o_bcd is the finished result in
//                   that same cycle, so a consumer can capture it on that edge
//   o_bcd         - DIGITS packed BCD digits, digit 0 in the LSBs
module bin_to_bcd_seq
  import mult_pkg::*;
#(
  parameter int unsigned IN_W   = 15,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [IN_W-1:0]       i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int unsigned    CntW    = (clog2(IN_W) > 0) ? clog2(IN_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(IN_W - 1);

  logic [IN_W-1:0]     r_bin;
  logic [4*DIGITS-1:0] r_bcd;
  logic [CntW-1:0]     r_cnt;
  logic                r_busy;
  logic [4*DIGITS-1:0] w_adj;
  logic [4*DIGITS-1:0] w_step;

  // Correct every digit, then shift in the next binary MSB.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_bcd[4*d +: 4] >= Add3Thresh) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
    end
    w_step = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_bin[IN_W-1]};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_bin  <= i_bin;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_bin <= r_bin << 1;
      r_bcd <= w_step;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CntLast) r_busy <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_cnt == CntLast);
  assign o_bcd  = w_step;

endmodule

// File: rtl/seq_mult_bcd.sv
// seq_mult_bcd
// Sequential signed multiplier (sign-magnitude shift-add) with BCD conversion
// of the product magnitude and a scrollable window of displayed digits.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start               - accept MP/MC in IDLE or DONE; ignored while busy
//   MP, MC              - signed operands
//   scroll_l, scroll_r  - move the window up / down one digit (saturating)
//   busy                - multiplying or converting
//   done                - a valid result is held
//   product, sign       - signed product and its sign (0 for a zero product)
//   zero_flag           - product is zero
//   win_digits          - BCD digits [offset+WINDOW-1 .. offset]
//   offset              - current window position
module seq_mult_bcd
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 5,
  parameter int unsigned WINDOW = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic signed [WIDTH-1:0]              MP,
  input  logic signed [WIDTH-1:0]              MC,
  input  logic                                 scroll_l,
  input  logic                                 scroll_r,
  output logic                                 busy,
  output logic                                 done,
  output logic signed [2*WIDTH-1:0]            product,
  output logic                                 sign,
  output logic                                 zero_flag,
  output logic [4*WINDOW-1:0]                  win_digits,
  output logic [off_width(DIGITS, WINDOW)-1:0] offset
);

  localparam int unsigned     OffW    = off_width(DIGITS, WINDOW);
  localparam logic [OffW-1:0] OffMax  = OffW'(DIGITS - WINDOW);
  localparam int unsigned     CntW    = (clog2(WIDTH) > 0) ? clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam int unsigned     MagW    = 2 * WIDTH - 1;
  localparam int unsigned     WinW    = 4 * WINDOW;

  state_e                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [2*WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]      r_mplier;
  logic [2*WIDTH-1:0]    r_acc;
  logic                  r_neg;
  logic [CntW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]    r_product;
  logic                  r_sign;
  logic                  r_zero;
  logic [4*DIGITS-1:0]   r_bcd_hold;
  logic [OffW-1:0]       r_offset;

  logic [WIDTH-1:0]      w_abs_mp;
  logic [WIDTH-1:0]      w_abs_mc;
  logic [2*WIDTH-1:0]    w_acc_next;
  logic                  w_accept;
  logic                  w_conv_load;
  logic                  w_conv_busy;
  logic                  w_conv_done;
  logic [4*DIGITS-1:0]   w_conv_bcd;
  logic                  w_nonzero;

  // Unsigned magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits.
  assign w_abs_mp   = MP[WIDTH-1] ? WIDTH'(-MP) : MP;
  assign w_abs_mc   = MC[WIDTH-1] ? WIDTH'(-MC) : MC;
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_accept   = start && ((r_state == StIdle) || (r_state == StDone));
  assign w_nonzero  = |r_acc;

  // Hand the final partial product straight to the converter on the last
  // multiply step so conversion starts with no idle cycle.
  assign w_conv_load = (r_state == StMult) && (r_cnt == CntLast) && !w_conv_busy;

  bin_to_bcd_seq #(
    .IN_W   (MagW),
    .DIGITS (DIGITS)
  ) u_bin_to_bcd (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_load (w_conv_load),
    .i_bin  (w_acc_next[MagW-1:0]),
    .o_busy (w_conv_busy),
    .o_done (w_conv_done),
    .o_bcd  (w_conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_neg      <= 1'b0;
      r_cnt      <= '0;
      r_product  <= '0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_bcd_hold <= '0;
      r_offset   <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_mc};
            r_mplier <= w_abs_mp;
            r_acc    <= '0;
            r_neg    <= MP[WIDTH-1] ^ MC[WIDTH-1];
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_state  <= StMult;
          end
        end
        StMult: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CntLast) r_state <= StConv;
        end
        StConv: begin
          if (w_conv_done) begin
            r_product  <= (r_neg && w_nonzero) ? -r_acc : r_acc;
            r_sign     <= r_neg && w_nonzero;
            r_zero     <= !w_nonzero;
            r_bcd_hold <= w_conv_bcd;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= StDone;
          end
        end
        default: r_state <= StIdle;
      endcase

      // Window position: start wins, simultaneous pulses cancel.
      if (w_accept) begin
        r_offset <= '0;
      end else if (scroll_l && !scroll_r && (r_offset != OffMax)) begin
        r_offset <= r_offset + 1'b1;
      end else if (scroll_r && !scroll_l && (r_offset != '0)) begin
        r_offset <= r_offset - 1'b1;
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign product    = r_product;
  assign sign       = r_sign;
  assign zero_flag  = r_zero;
  assign offset     = r_offset;
  assign win_digits = WinW'(r_bcd_hold >> {r_offset, 2'b00});

endmodule

// File: doc/seq_mult_bcd.md
SEQ_MULT_BCD -- requirements
Module: seq_mult_bcd

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width, signed two's complement, minimum 2.
REQ-002 SHALL have parameter DIGITS, default 5: BCD digits of product magnitude; 10^DIGITS > 2^(2*WIDTH-2) is required.
REQ-003 SHALL have parameter WINDOW, default 3: digits presented for display; 1 <= WINDOW <= DIGITS.
REQ-004 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have start  input  1  one-cycle request to multiply the current MP and MC.
REQ-007 SHALL have MP, MC  input  WIDTH  signed multiplier and multiplicand.
REQ-008 SHALL have scroll_l, scroll_r  input  1  single-cycle, already-debounced pulses that shift the display window.
REQ-009 SHALL have busy  output  1  high while multiplying or converting.
REQ-010 SHALL have done  output  1  level, high while a valid result is held.
REQ-011 SHALL have product  output  2*WIDTH  signed product.
REQ-012 SHALL have sign  output  1  product negative; zero_flag  output  1  product equals zero.
REQ-013 SHALL have win_digits  output  4*WINDOW  BCD digits bcd[offset+WINDOW-1 .. offset], with digit 0 in the LSBs.
REQ-014 SHALL have offset  output  clog2(DIGITS-WINDOW+1), minimum 1  current window position.

Function
REQ-015 SHALL implement FSM states IDLE, MULT, CONV, DONE.
REQ-016 SHALL accept start only in IDLE or DONE, latching |MP|, |MC| (unsigned WIDTH bits) and sign(MP) xor sign(MC), then entering MULT; start in MULT/CONV SHALL be ignored.
REQ-017 MULT SHALL perform unsigned shift-add for exactly WIDTH cycles, then enter CONV.
REQ-018 CONV SHALL run shift-add-3 (double dabble) on the (2*WIDTH-1)-bit magnitude for exactly 2*WIDTH-1 cycles, then enter DONE.
REQ-019 done SHALL rise 3*WIDTH-1 edges after the edge that accepted start (23 for WIDTH=8); busy SHALL be high in exactly MULT and CONV.
REQ-020 product, sign, zero_flag and the BCD digits SHALL update only on entry to DONE and SHALL hold until the next entry to DONE.
REQ-021 For a zero product, sign SHALL be 0 and zero_flag 1; otherwise product = sign ? -magnitude : magnitude.
REQ-022 -2^(WIDTH-1) operands SHALL be handled; (-128)*(-128) = 16384 for WIDTH=8.
REQ-023 scroll_l SHALL increment offset, saturating at DIGITS-WINDOW; scroll_r SHALL decrement it, saturating at 0.
REQ-024 scroll_l and scroll_r in the same cycle SHALL leave offset unchanged.
REQ-025 Scrolling SHALL be honoured in every state.
REQ-026 offset SHALL be forced to 0 on start acceptance, which overrides a same-cycle scroll.
REQ-027 win_digits SHALL be combinational from the held BCD register and offset, with no added latency.
REQ-028 start in DONE SHALL deassert done on the next edge.

Reset
REQ-029 rst SHALL immediately force IDLE and clear busy, done, product, sign, zero_flag, win_digits, offset and all internal registers to 0.
REQ-030 rst asserted during MULT/CONV SHALL abort the operation with no result update.
REQ-031 After rst deasserts, the first start SHALL behave as from IDLE.

Structure
REQ-032 A shared package mult_pkg SHALL hold the FSM state encodings, a clog2 function and the add-3 threshold constant (4'd5).
REQ-033 Double dabble SHALL be the sub-module bin_to_bcd_seq, which has load/busy/done handshake and is parameterised by input width and DIGITS.
REQ-034 The sign-magnitude multiply datapath and the window mux SHALL stay in seq_mult_bcd.

Verification
REQ-035 Positive multiply: WIDTH=8, MP=12, MC=11, start -> done after 23 edges, product=132, sign=0, win_digits=1,3,2 (hundreds, tens, units).
REQ-036 Negative multiply: MP=-128, MC=127 -> product=-16256, sign=1, zero_flag=0; three scroll_l -> offset saturates at 2, win_digits=1,6,2 (ten-thousands, thousands, hundreds).
REQ-037 Zero product: MP=0, MC=-5 -> product=0, sign=0, zero_flag=1.
REQ-038 Ignored start: second start 5 cycles into MULT with new operands -> first result still delivered, second start ignored; scroll_l and scroll_r together -> offset unchanged.
REQ-039 Reset mid-operation: rst 10 cycles into MULT -> all outputs 0 asynchronously; prior result not restored.
REQ-040 Back-to-back from DONE: start in DONE -> done low next edge, offset=0, new result 23 edges later.
